// File: rtl/mac_stream.sv
// Streaming signed fixed-point multiply-accumulate: one rounded, saturated dot product per framed vector.
// Two stages (product, accumulate/result) share a single advance enable driven by output backpressure.
module mac_stream #(
    parameter int N_LEN       = 16,
    parameter int Q_LEN       = 8,
    parameter int ACC_GUARD   = 8,
    parameter int RND_NEAREST = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_LEN-1:0] in_a,
    input  logic [N_LEN-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_LEN-1:0] out_res,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int unsigned P_W    = 2 * N_LEN;
    localparam int unsigned ACC_W  = P_W + ACC_GUARD;
    localparam int unsigned R_W    = ACC_W + 1;
    localparam int unsigned RND_SH = (Q_LEN > 0) ? Q_LEN - 1 : 0;
    localparam logic [R_W-1:0] RND_ADD =
        (RND_NEAREST != 0 && Q_LEN > 0) ? (R_W'(1) << RND_SH) : '0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

    logic en_c;
    logic beat_c;
    logic step_c;

    // The whole pipe advances unless a result is waiting to be taken.
    assign en_c     = ~out_valid | out_ready;
    assign in_ready = en_c & ~rst;
    assign beat_c   = in_valid & in_ready;

    logic signed [P_W-1:0] p_prod;
    logic                  p_valid;
    logic                  p_first;
    logic                  p_last;

    // Product stage
    always_ff @(posedge clk) begin
        if (rst) begin
            p_prod  <= '0;
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else if (en_c) begin
            p_prod  <= $signed(in_a) * $signed(in_b);
            p_valid <= beat_c;
            p_first <= in_first;
            p_last  <= in_last;
        end
    end

    assign step_c = en_c & p_valid;

    logic [0:0]              state;
    logic [0:0]              state_next;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;

    logic                    start_c;
    logic signed [ACC_W-1:0] acc_base_c;
    logic signed [ACC_W-1:0] prod_ext_c;
    logic signed [ACC_W-1:0] acc_next_c;
    logic                    add_ovf_c;
    logic                    ovf_next_c;
    logic [CNT_W-1:0]        cnt_next_c;
    logic signed [R_W-1:0]   rounded_c;
    logic signed [R_W-1:0]   shifted_c;
    logic                    fits_c;
    logic [N_LEN-1:0]        sat_res_c;

    // Accumulate, round and saturate; rounding is done one bit wider so it cannot wrap.
    always_comb begin
        start_c    = p_first | (state == S_IDLE);
        acc_base_c = start_c ? '0 : acc;
        prod_ext_c = {{ACC_GUARD{p_prod[P_W-1]}}, p_prod};
        acc_next_c = acc_base_c + prod_ext_c;
        add_ovf_c  = (acc_base_c[ACC_W-1] == prod_ext_c[ACC_W-1]) &&
                     (acc_next_c[ACC_W-1] != acc_base_c[ACC_W-1]);
        ovf_next_c = (start_c ? 1'b0 : ovf) | add_ovf_c;
        cnt_next_c = start_c ? CNT_W'(1) : cnt + CNT_W'(1);
        rounded_c  = $signed({acc_next_c[ACC_W-1], acc_next_c}) + $signed(RND_ADD);
        shifted_c  = rounded_c >>> Q_LEN;
        fits_c     = (&shifted_c[R_W-1:N_LEN-1]) | ~(|shifted_c[R_W-1:N_LEN-1]);
        if (fits_c) begin
            sat_res_c = shifted_c[N_LEN-1:0];
        end else if (shifted_c[R_W-1]) begin
            sat_res_c = {1'b1, {(N_LEN-1){1'b0}}};
        end else begin
            sat_res_c = {1'b0, {(N_LEN-1){1'b1}}};
        end
    end

    // Framing FSM next state
    always_comb begin
        state_next = state;
        if (step_c) begin
            state_next = p_last ? S_IDLE : S_ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator, term counter and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (step_c) begin
            acc <= acc_next_c;
            cnt <= cnt_next_c;
            ovf <= ovf_next_c;
        end
    end

    // Result register; holds while stalled, drops valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_ovf   <= 1'b0;
            out_cnt   <= '0;
        end else if (en_c) begin
            out_valid <= p_valid & p_last;
            if (p_valid && p_last) begin
                out_res <= sat_res_c;
                out_ovf <= ~fits_c | ovf_next_c;
                out_cnt <= cnt_next_c;
            end
        end
    end

endmodule

// File: tb/tb_mac_stream.sv
// Directed bench for mac_stream: two instances (round-nearest and truncate) share stimulus,
// results are predicted by a behavioural model into a queue and checked when consumed.
module tb_mac_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_first;
    logic        in_last;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [15:0] res0, res1;
    logic        ovf0, ovf1;
    logic [7:0]  cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] res_rn;
        logic [15:0] res_tr;
        logic        ovf_rn;
        logic        ovf_tr;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];

    longint m_acc;
    bit     m_busy;
    int     m_cnt;
    bit     m_ovf;

    localparam longint ACC_MAX = (64'sd1 <<< 39) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< 39);

    always #5 clk = ~clk;

    mac_stream dut_rn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_res(res0),
        .out_ovf(ovf0), .out_cnt(cnt0)
    );

    mac_stream #(.RND_NEAREST(0)) dut_tr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_res(res1),
        .out_ovf(ovf1), .out_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void round_sat(input longint s, input bit rnd,
                                      output logic [15:0] r, output bit sat);
        longint t;
        t   = (s + (rnd ? 64'sd128 : 64'sd0)) >>> 8;
        sat = 1'b0;
        if (t > 32767) begin
            t = 32767; sat = 1'b1;
        end else if (t < -32768) begin
            t = -32768; sat = 1'b1;
        end
        r = 16'(t);
    endfunction

    function automatic void model_reset();
        m_acc = 0; m_busy = 0; m_cnt = 0; m_ovf = 0;
    endfunction

    function automatic void model_beat(input logic [15:0] a, input logic [15:0] b,
                                       input logic f, input logic l);
        longint p, s;
        bit     start, o, sat;
        exp_t   e;
        p     = longint'($signed(a)) * longint'($signed(b));
        start = f || !m_busy;
        s     = (start ? 64'sd0 : m_acc) + p;
        o     = (s > ACC_MAX) || (s < ACC_MIN);
        if (o) s = (s <<< 24) >>> 24;
        m_ovf  = (start ? 1'b0 : m_ovf) | o;
        m_cnt  = start ? 1 : m_cnt + 1;
        m_acc  = s;
        m_busy = !l;
        if (l) begin
            round_sat(s, 1'b1, e.res_rn, sat);
            e.ovf_rn = sat | m_ovf;
            round_sat(s, 1'b0, e.res_tr, sat);
            e.ovf_tr = sat | m_ovf;
            e.cnt    = 8'(m_cnt);
            q.push_back(e);
        end
    endfunction

    task automatic check_out();
        exp_t e;
        chk("result_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("valid_tr", 32'(out_valid1), 1);
            chk("res_rn", 32'(res0), 32'(e.res_rn));
            chk("res_tr", 32'(res1), 32'(e.res_tr));
            chk("ovf_rn", 32'(ovf0), 32'(e.ovf_rn));
            chk("ovf_tr", 32'(ovf1), 32'(e.ovf_tr));
            chk("cnt_rn", 32'(cnt0), 32'(e.cnt));
            chk("cnt_tr", 32'(cnt1), 32'(e.cnt));
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance to just after the edge.
    task automatic tick(output bit accepted);
        #1;
        accepted = in_valid && in_ready0;
        if (out_valid0 && out_ready) check_out();
        if (accepted) model_beat(in_a, in_b, in_first, in_last);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        bit acc;
        tick(acc);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic f, input logic l);
        bit acc;
        int n;
        in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            tick(acc);
            if (!acc) out_ready = 1'b1;
            n++;
        end
        chk("send_accept", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid0) && n < 40) begin
            step();
            n++;
        end
        chk("drain_done", 32'(q.size()), 0);
    endtask

    initial begin
        logic [15:0] held;
        int          len;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (3) step();
        chk("rst_valid", 32'(out_valid0), 0);
        chk("rst_res", 32'(res0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_ready", 32'(in_ready0), 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(in_ready0), 1);

        // Single-term vector and latency: valid rises on the second edge counting the accept edge.
        send(16'h0180, 16'h0200, 1'b1, 1'b1);
        chk("lat_first_edge", 32'(out_valid0), 0);
        step();
        chk("lat_second_edge", 32'(out_valid0), 1);
        chk("single_res", 32'(res0), 32'h0300);
        drain();

        // Three-term vector, back-to-back beats.
        send(16'h0100, 16'h0100, 1'b1, 1'b0);
        send(16'h0080, 16'h0200, 1'b0, 1'b0);
        send(16'hFFC0, 16'h0400, 1'b0, 1'b1);
        drain();

        // Rounding corners, back-to-back single-term vectors.
        send(16'h0001, 16'h0080, 1'b1, 1'b1);
        send(16'hFFFF, 16'h0080, 1'b1, 1'b1);
        drain();

        // Saturation both directions.
        send(16'h7F00, 16'h0200, 1'b1, 1'b1);
        send(16'h8000, 16'h7FFF, 1'b1, 1'b1);
        drain();

        // Backpressure across two back-to-back two-term vectors.
        out_ready = 1'b0;
        send(16'h0100, 16'h0100, 1'b1, 1'b0);
        send(16'h0200, 16'h0100, 1'b0, 1'b1);
        send(16'h0080, 16'h0080, 1'b1, 1'b0);
        in_a = 16'hFF00; in_b = 16'h0300; in_first = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        held = res0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", 32'(in_ready0), 0);
            chk("bp_valid_held", 32'(out_valid0), 1);
            chk("bp_res_stable", 32'(res0), 32'(held));
            step();
        end
        out_ready = 1'b1;
        send(16'hFF00, 16'h0300, 1'b0, 1'b1);
        drain();

        // A first beat mid-vector restarts it.
        send(16'h0100, 16'h0300, 1'b1, 1'b0);
        send(16'h0200, 16'h0200, 1'b0, 1'b0);
        send(16'h0100, 16'h0100, 1'b1, 1'b0);
        send(16'h0080, 16'h0200, 1'b0, 1'b1);
        drain();

        // Random vectors with intermittent backpressure.
        for (int v = 0; v < 6; v++) begin
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                     1'(k == 0), 1'(k == len - 1));
            end
        end
        drain();

        // Reset in the middle of a vector drops the partial sum.
        send(16'h0300, 16'h0100, 1'b1, 1'b0);
        send(16'h0200, 16'h0100, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        chk("midrst_valid", 32'(out_valid0), 0);
        chk("midrst_res", 32'(res0), 0);
        chk("midrst_cnt", 32'(cnt0), 0);
        chk("midrst_ready", 32'(in_ready0), 0);
        model_reset();
        q.delete();
        rst = 1'b0;
        send(16'h0100, 16'h0100, 1'b1, 1'b1);
        step();
        chk("post_rst_valid", 32'(out_valid0), 1);
        chk("post_rst_res", 32'(res0), 32'h0100);
        chk("post_rst_cnt", 32'(cnt0), 1);
        drain();
        repeat (3) begin
            chk("no_stale_valid", 32'(out_valid0), 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
